// File: rtl/pc_gen.sv
// Fetch-stage program counter with boot cycle, branch/flush redirect
// and a pending-branch slot for redirects that arrive under stall.
module pc_gen #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     ALIGN_B   = 2,
  parameter int unsigned     STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  input  logic               branch_flag,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc,
  output logic               ce,
  output logic               pc_misalign,
  output logic               redirect_pend
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_PEND
  } state_e;

  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

  // ALIGN_B=0 yields an all-zero mask, which disables the check
  localparam logic [PC_W-1:0] ALIGN_MASK =
    ~({PC_W{1'b1}} << ALIGN_B);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic            ce_q, ce_d;
  logic            misalign_q, misalign_d;
  logic            stall_pc;

  assign stall_pc = stall[0];

  // only the PC-stage bit matters here
  logic unused_stall;
  assign unused_stall = ^stall;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    ce_d      = ce_q;
    case (state_q)
      S_BOOT: begin
        ce_d    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN, S_PEND: begin
        ce_d = 1'b1;
        if (flush) begin
          pc_d      = flush_pc;
          pend_pc_d = '0;
          state_d   = S_RUN;
        end else if (branch_flag && !stall_pc) begin
          pc_d    = branch_target;
          state_d = S_RUN;
        end else if (branch_flag) begin
          pend_pc_d = branch_target;
          state_d   = S_PEND;
        end else if (state_q == S_PEND && !stall_pc) begin
          pc_d    = pend_pc_q;
          state_d = S_RUN;
        end else if (!stall_pc) begin
          pc_d = pc_q + INC_V;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
    misalign_d = |(pc_d & ALIGN_MASK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VEC;
      pend_pc_q  <= '0;
      ce_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      ce_q       <= ce_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc            = pc_q;
  assign ce            = ce_q;
  assign pc_misalign   = misalign_q;
  assign redirect_pend = (state_q == S_PEND);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot, stall, branch, pending branch,
// flush priority, misalign, wrap and reset during a pending redirect.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        ce;
  logic        pc_misalign;
  logic        redirect_pend;

  int checks;
  int errors;

  pc_gen #(
    .PC_W     (32),
    .RESET_VEC(32'h100),
    .INC      (4),
    .ALIGN_B  (2),
    .STALL_W  (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .pc           (pc),
    .ce           (ce),
    .pc_misalign  (pc_misalign),
    .redirect_pend(redirect_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    stall         = '0;
    flush         = 1'b0;
    flush_pc      = '0;
    branch_flag   = 1'b0;
    branch_target = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ce !== 1'b0 || pc !== 32'h100 || redirect_pend !== 1'b0
          || pc_misalign !== 1'b0) begin
        errors++;
        $display("FAIL reset_%0d: pc=%h ce=%b pend=%b mis=%b exp pc=100 ce=0 pend=0 mis=0",
                 i, pc, ce, redirect_pend, pc_misalign);
      end
    end
  endtask

  task automatic test_boot;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h100;
    exp_pc[1] = 32'h104;
    exp_pc[2] = 32'h108;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== exp_pc[i] || ce !== 1'b1) begin
        errors++;
        $display("FAIL boot_%0d: pc=%h ce=%b exp pc=%h ce=1",
                 i, pc, ce, exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall;
    stall = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h108 || ce !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: pc=%h ce=%b exp pc=108 ce=1",
                 i, pc, ce);
      end
    end
    stall = 6'b000000;
    tick();
    checks++;
    if (pc !== 32'h10C) begin
      errors++;
      $display("FAIL stall_release: pc=%h exp 10c", pc);
    end
    stall = 6'b111110;
    tick();
    checks++;
    if (pc !== 32'h110) begin
      errors++;
      $display("FAIL stall_upper_bits: pc=%h exp 110", pc);
    end
    stall = '0;
  endtask

  task automatic test_branch;
    branch_flag   = 1'b1;
    branch_target = 32'h200;
    tick();
    checks++;
    if (pc !== 32'h200 || redirect_pend !== 1'b0) begin
      errors++;
      $display("FAIL branch_take: pc=%h pend=%b exp pc=200 pend=0",
               pc, redirect_pend);
    end
    branch_flag = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h204) begin
      errors++;
      $display("FAIL branch_next: pc=%h exp 204", pc);
    end
  endtask

  task automatic test_branch_stall;
    stall         = 6'b000001;
    branch_flag   = 1'b1;
    branch_target = 32'h300;
    tick();
    checks++;
    if (pc !== 32'h204 || redirect_pend !== 1'b1) begin
      errors++;
      $display("FAIL pend_enter: pc=%h pend=%b exp pc=204 pend=1",
               pc, redirect_pend);
    end
    branch_flag = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h204 || redirect_pend !== 1'b1) begin
      errors++;
      $display("FAIL pend_hold: pc=%h pend=%b exp pc=204 pend=1",
               pc, redirect_pend);
    end
    stall = '0;
    tick();
    checks++;
    if (pc !== 32'h300 || redirect_pend !== 1'b0) begin
      errors++;
      $display("FAIL pend_release: pc=%h pend=%b exp pc=300 pend=0",
               pc, redirect_pend);
    end
    // a second branch while pending replaces the first target
    stall         = 6'b000001;
    branch_flag   = 1'b1;
    branch_target = 32'h500;
    tick();
    branch_target = 32'h600;
    tick();
    branch_flag = 1'b0;
    stall       = '0;
    tick();
    checks++;
    if (pc !== 32'h600 || redirect_pend !== 1'b0) begin
      errors++;
      $display("FAIL pend_overwrite: pc=%h pend=%b exp pc=600 pend=0",
               pc, redirect_pend);
    end
  endtask

  task automatic test_priority;
    stall         = 6'b000001;
    branch_flag   = 1'b1;
    branch_target = 32'h700;
    tick();
    checks++;
    if (redirect_pend !== 1'b1 || pc !== 32'h600) begin
      errors++;
      $display("FAIL prio_setup: pc=%h pend=%b exp pc=600 pend=1",
               pc, redirect_pend);
    end
    flush         = 1'b1;
    flush_pc      = 32'h80;
    branch_target = 32'h400;
    tick();
    checks++;
    if (pc !== 32'h80 || redirect_pend !== 1'b0) begin
      errors++;
      $display("FAIL prio_flush: pc=%h pend=%b exp pc=80 pend=0",
               pc, redirect_pend);
    end
    idle();
    tick();
    checks++;
    if (pc !== 32'h84) begin
      errors++;
      $display("FAIL prio_pend_cleared: pc=%h exp 84", pc);
    end
    branch_flag   = 1'b1;
    branch_target = 32'h402;
    tick();
    checks++;
    if (pc !== 32'h402 || pc_misalign !== 1'b1) begin
      errors++;
      $display("FAIL misalign_set: pc=%h mis=%b exp pc=402 mis=1",
               pc, pc_misalign);
    end
    branch_target = 32'h500;
    tick();
    checks++;
    if (pc !== 32'h500 || pc_misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear: pc=%h mis=%b exp pc=500 mis=0",
               pc, pc_misalign);
    end
    idle();
    tick();
    checks++;
    if (pc !== 32'h504 || pc_misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_inc: pc=%h mis=%b exp pc=504 mis=0",
               pc, pc_misalign);
    end
  endtask

  task automatic test_wrap_reset;
    branch_flag   = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_flag = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h0 || ce !== 1'b1) begin
      errors++;
      $display("FAIL wrap: pc=%h ce=%b exp pc=0 ce=1", pc, ce);
    end
    stall         = 6'b000001;
    branch_flag   = 1'b1;
    branch_target = 32'h800;
    tick();
    checks++;
    if (redirect_pend !== 1'b1 || pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pend: pc=%h pend=%b exp pc=0 pend=1",
               pc, redirect_pend);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h100 || ce !== 1'b0 || redirect_pend !== 1'b0) begin
      errors++;
      $display("FAIL rst_pend: pc=%h ce=%b pend=%b exp pc=100 ce=0 pend=0",
               pc, ce, redirect_pend);
    end
    // boot cycle must ignore every control input
    rst      = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h900;
    tick();
    checks++;
    if (pc !== 32'h100 || ce !== 1'b1 || redirect_pend !== 1'b0) begin
      errors++;
      $display("FAIL reboot: pc=%h ce=%b pend=%b exp pc=100 ce=1 pend=0",
               pc, ce, redirect_pend);
    end
    idle();
    tick();
    checks++;
    if (pc !== 32'h104 || redirect_pend !== 1'b0) begin
      errors++;
      $display("FAIL reboot_next: pc=%h pend=%b exp pc=104 pend=0",
               pc, redirect_pend);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_boot();
    test_stall();
    test_branch();
    test_branch_stall();
    test_priority();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
